// File: rtl/adpcm_pkg.sv
// Shared definitions for the ADPCM encoder/decoder cores: step table,
// state encoding, index adaptation and saturation helpers.
package adpcm_pkg;

  localparam int IDX_MAX = 88;

  localparam logic [15:0] STEP_TABLE [0:88] = '{
    16'd7,     16'd8,     16'd9,     16'd10,    16'd11,    16'd12,    16'd13,    16'd14,
    16'd16,    16'd17,    16'd19,    16'd21,    16'd23,    16'd25,    16'd28,    16'd31,
    16'd34,    16'd37,    16'd41,    16'd45,    16'd50,    16'd55,    16'd60,    16'd66,
    16'd73,    16'd80,    16'd88,    16'd97,    16'd107,   16'd118,   16'd130,   16'd143,
    16'd157,   16'd173,   16'd190,   16'd209,   16'd230,   16'd253,   16'd279,   16'd307,
    16'd337,   16'd371,   16'd408,   16'd449,   16'd494,   16'd544,   16'd598,   16'd658,
    16'd724,   16'd796,   16'd876,   16'd963,   16'd1060,  16'd1166,  16'd1282,  16'd1411,
    16'd1552,  16'd1707,  16'd1878,  16'd2066,  16'd2272,  16'd2499,  16'd2749,  16'd3024,
    16'd3327,  16'd3660,  16'd4026,  16'd4428,  16'd4871,  16'd5358,  16'd5894,  16'd6484,
    16'd7132,  16'd7845,  16'd8630,  16'd9493,  16'd10442, 16'd11487, 16'd12635, 16'd13899,
    16'd15289, 16'd16818, 16'd18500, 16'd20350, 16'd22385, 16'd24623, 16'd27086, 16'd29794,
    16'd32767
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIFF,
    ST_QUANT,
    ST_UPDATE,
    ST_OUT
  } enc_state_e;

  // Step-index adaptation: small magnitudes shrink the step, large ones grow it.
  function automatic int idx_adjust(input int mag, input int mb);
    int h;
    h = 1 << (mb - 1);
    if (mag < h) return -1;
    return 2 * (mag - h + 1);
  endfunction

  // Clamp a wide signed value into the signed range of a data_w-bit word.
  function automatic logic signed [31:0] sat(input logic signed [31:0] value, input int data_w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (data_w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (data_w - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/adpcm_enc_core_dequant.sv
// Reconstructs the quantised difference magnitude from a step size and the
// magnitude bits of a code; shared with the decoder.
module adpcm_dequant
  import adpcm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int MB     = 3
) (
  input  logic [DATA_W-1:0] step,
  input  logic [MB-1:0]     mag,
  output logic [DATA_W:0]   dq
);

  // Half-LSB rounding term plus one scaled step per set magnitude bit.
  always_comb begin
    logic [DATA_W:0] step_ext;
    step_ext = {1'b0, step};
    dq = step_ext >> MB;
    for (int k = 0; k < MB; k++) begin
      if (mag[k]) dq = dq + (step_ext >> (MB - 1 - k));
    end
  end

endmodule

// File: rtl/adpcm_enc_core.sv
// Multi-channel sequential IMA-style ADPCM encoder: one sample in flight,
// one magnitude bit resolved per cycle, per-channel predictor/index state.
module adpcm_enc_core
  import adpcm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CODE_W = 4,
  parameter int NUM_CH = 4,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int MB    = CODE_W - 1,
  localparam int CNT_W = (MB > 1) ? $clog2(MB) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DATA_W-1:0] in_sample,
  input  logic                     clr_valid,
  input  logic [CH_W-1:0]          clr_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic [CODE_W-1:0]        out_code,
  output logic signed [DATA_W-1:0] out_predicted,
  output logic [6:0]               out_index
);

  enc_state_e state, state_nxt;

  logic signed [DATA_W-1:0] pred_mem [NUM_CH];
  logic [6:0]               idx_mem  [NUM_CH];

  logic [CH_W-1:0]          cur_ch;
  logic signed [DATA_W-1:0] cur_sample;
  logic signed [DATA_W-1:0] pred_cur;
  logic [6:0]               idx_cur;
  logic [DATA_W-1:0]        step_cur;
  logic                     sign_cur;
  logic [DATA_W:0]          rem;
  logic [MB-1:0]            mag_bits;
  logic [CNT_W-1:0]         bit_cnt;
  logic                     clr_hit;

  logic signed [DATA_W:0]   diff;
  logic [DATA_W:0]          diff_abs;
  logic [DATA_W:0]          cmp;
  logic [DATA_W:0]          dq;
  logic signed [DATA_W-1:0] pred_new;
  logic [6:0]               idx_new;

  adpcm_dequant #(.DATA_W(DATA_W), .MB(MB)) u_dequant (
    .step (step_cur),
    .mag  (mag_bits),
    .dq   (dq)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: one DIFF cycle, MB QUANT cycles, one UPDATE, then hold in OUT until accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (in_valid) state_nxt = ST_DIFF;
      ST_DIFF:   state_nxt = ST_QUANT;
      ST_QUANT:  if (bit_cnt == '0) state_nxt = ST_UPDATE;
      ST_UPDATE: state_nxt = ST_OUT;
      ST_OUT:    if (out_valid && out_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state.
  always_comb begin
    in_ready = (state == ST_IDLE);
  end

  // Difference, comparison threshold and updated predictor/index for the sample in flight.
  always_comb begin
    logic signed [31:0] pred_ext;
    logic signed [31:0] dq_ext;
    logic signed [31:0] sum;
    logic signed [31:0] sat_val;
    logic signed [31:0] idx_sum;
    diff     = {cur_sample[DATA_W-1], cur_sample} - {pred_mem[cur_ch][DATA_W-1], pred_mem[cur_ch]};
    diff_abs = diff[DATA_W] ? $unsigned(-diff) : $unsigned(diff);
    cmp      = {1'b0, step_cur} >> (CNT_W'(MB - 1) - bit_cnt);
    pred_ext = 32'(pred_cur);
    dq_ext   = 32'(dq);
    sum      = sign_cur ? (pred_ext - dq_ext) : (pred_ext + dq_ext);
    sat_val  = sat(sum, DATA_W);
    pred_new = sat_val[DATA_W-1:0];
    idx_sum  = int'(idx_cur) + idx_adjust(int'(mag_bits), MB);
    if (idx_sum < 0)             idx_new = 7'd0;
    else if (idx_sum > IDX_MAX)  idx_new = 7'(IDX_MAX);
    else                         idx_new = idx_sum[6:0];
  end

  // Sample datapath: capture, successive approximation and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_ch        <= '0;
      cur_sample    <= '0;
      pred_cur      <= '0;
      idx_cur       <= '0;
      step_cur      <= '0;
      sign_cur      <= 1'b0;
      rem           <= '0;
      mag_bits      <= '0;
      bit_cnt       <= '0;
      clr_hit       <= 1'b0;
      out_valid     <= 1'b0;
      out_ch        <= '0;
      out_code      <= '0;
      out_predicted <= '0;
      out_index     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            cur_ch     <= in_ch;
            cur_sample <= in_sample;
            clr_hit    <= 1'b0;
          end
        end
        ST_DIFF: begin
          pred_cur <= pred_mem[cur_ch];
          idx_cur  <= idx_mem[cur_ch];
          step_cur <= DATA_W'(STEP_TABLE[idx_mem[cur_ch]]);
          sign_cur <= diff[DATA_W];
          rem      <= diff_abs;
          mag_bits <= '0;
          bit_cnt  <= CNT_W'(MB - 1);
        end
        ST_QUANT: begin
          if (rem >= cmp) begin
            mag_bits[bit_cnt] <= 1'b1;
            rem               <= rem - cmp;
          end
          bit_cnt <= bit_cnt - 1'b1;
        end
        ST_UPDATE: begin
          out_ch        <= cur_ch;
          out_code      <= {sign_cur, mag_bits};
          out_predicted <= pred_new;
          out_index     <= idx_new;
        end
        ST_OUT: begin
          out_valid <= !(out_valid && out_ready);
        end
        default: ;
      endcase
      if (clr_valid && (clr_ch == cur_ch) &&
          (state == ST_DIFF || state == ST_QUANT || state == ST_UPDATE))
        clr_hit <= 1'b1;
    end
  end

  // Per-channel state: clear has priority over the write-back of the sample in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        pred_mem[i] <= '0;
        idx_mem[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clr_valid && (clr_ch == CH_W'(i))) begin
          pred_mem[i] <= '0;
          idx_mem[i]  <= '0;
        end else if ((state == ST_UPDATE) && (cur_ch == CH_W'(i)) && !clr_hit) begin
          pred_mem[i] <= pred_new;
          idx_mem[i]  <= idx_new;
        end
      end
    end
  end

endmodule

// File: tb/tb_adpcm_enc_core.sv
// Directed self-checking bench for adpcm_enc_core (DATA_W=16, CODE_W=4, NUM_CH=4).
module tb_adpcm_enc_core;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_ch;
  logic signed [15:0] in_sample;
  logic               clr_valid;
  logic [1:0]         clr_ch;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_ch;
  logic [3:0]         out_code;
  logic signed [15:0] out_predicted;
  logic [6:0]         out_index;

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  adpcm_enc_core #(.DATA_W(16), .CODE_W(4), .NUM_CH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_ch         (in_ch),
    .in_sample     (in_sample),
    .clr_valid     (clr_valid),
    .clr_ch        (clr_ch),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_ch        (out_ch),
    .out_code      (out_code),
    .out_predicted (out_predicted),
    .out_index     (out_index)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait (bounded) for out_valid; called 1 ns after a rising edge.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      cmp_cnt++; fail_cnt++;
      $display("[TB] FAIL out_valid_timeout: out_valid=%b after %0d cycles, required 1", out_valid, lat);
    end
  endtask

  // Offer one sample, wait for the result, capture it and complete the handshake.
  task automatic encode(input logic [1:0] ch, input logic signed [15:0] sample,
                        output logic [1:0] rch, output logic [3:0] code,
                        output logic signed [15:0] pred, output logic [6:0] idx,
                        output int lat);
    int n;
    in_ch = ch; in_sample = sample; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      cmp_cnt++; fail_cnt++;
      $display("[TB] FAIL in_ready_timeout: in_ready=%b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    rch = out_ch; code = out_code; pred = out_predicted; idx = out_index;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_sample = '0;
    clr_valid = 1'b0; clr_ch = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp_cnt++; if (in_ready !== 1'b1) begin fail_cnt++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    cmp_cnt++; if (out_valid !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    cmp_cnt++; if (out_code !== 4'd0) begin fail_cnt++; $display("[TB] FAIL reset_out_code: got %b want 0000", out_code); end
    cmp_cnt++; if (out_predicted !== 16'sd0) begin fail_cnt++; $display("[TB] FAIL reset_out_predicted: got %0d want 0", out_predicted); end
    cmp_cnt++; if (out_index !== 7'd0) begin fail_cnt++; $display("[TB] FAIL reset_out_index: got %0d want 0", out_index); end
    cmp_cnt++; if (out_ch !== 2'd0) begin fail_cnt++; $display("[TB] FAIL reset_out_ch: got %0d want 0", out_ch); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [1:0] rch; logic [3:0] code; logic signed [15:0] pred; logic [6:0] idx; int lat;
    encode(2'd0, 16'sd1000, rch, code, pred, idx, lat);
    cmp_cnt++; if (lat !== 6) begin fail_cnt++; $display("[TB] FAIL basic_latency: got %0d want 6", lat); end
    cmp_cnt++; if (rch !== 2'd0) begin fail_cnt++; $display("[TB] FAIL basic_ch: got %0d want 0", rch); end
    cmp_cnt++; if (code !== 4'b0111) begin fail_cnt++; $display("[TB] FAIL basic_code: got %b want 0111", code); end
    cmp_cnt++; if (pred !== 16'sd11) begin fail_cnt++; $display("[TB] FAIL basic_pred: got %0d want 11", pred); end
    cmp_cnt++; if (idx !== 7'd8) begin fail_cnt++; $display("[TB] FAIL basic_idx: got %0d want 8", idx); end
    cmp_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fail_cnt++; $display("[TB] FAIL basic_after_handshake: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_negative();
    logic [1:0] rch; logic [3:0] code; logic signed [15:0] pred; logic [6:0] idx; int lat;
    encode(2'd1, -16'sd1000, rch, code, pred, idx, lat);
    cmp_cnt++; if (rch !== 2'd1) begin fail_cnt++; $display("[TB] FAIL neg_ch: got %0d want 1", rch); end
    cmp_cnt++; if (code !== 4'b1111) begin fail_cnt++; $display("[TB] FAIL neg_code: got %b want 1111", code); end
    cmp_cnt++; if (pred !== -16'sd11) begin fail_cnt++; $display("[TB] FAIL neg_pred: got %0d want -11", pred); end
    cmp_cnt++; if (idx !== 7'd8) begin fail_cnt++; $display("[TB] FAIL neg_idx: got %0d want 8", idx); end
  endtask

  task automatic test_small();
    logic [1:0] rch; logic [3:0] code; logic signed [15:0] pred; logic [6:0] idx; int lat;
    encode(2'd2, 16'sd2, rch, code, pred, idx, lat);
    cmp_cnt++; if (code !== 4'b0001) begin fail_cnt++; $display("[TB] FAIL small_code: got %b want 0001", code); end
    cmp_cnt++; if (pred !== 16'sd1) begin fail_cnt++; $display("[TB] FAIL small_pred: got %0d want 1", pred); end
    cmp_cnt++; if (idx !== 7'd0) begin fail_cnt++; $display("[TB] FAIL small_idx_clamp_low: got %0d want 0", idx); end
  endtask

  // ch0 starts from 11/8 (left by test_basic, untouched by the ch1/ch2 samples).
  task automatic test_saturation();
    logic [1:0] rch; logic [3:0] code; logic signed [15:0] pred; logic [6:0] idx; int lat;
    int exp_pred [9] = '{41, 104, 240, 533, 1164, 2521, 5431, 11667, 25039};
    for (int i = 0; i < 9; i++) begin
      encode(2'd0, 16'sd32767, rch, code, pred, idx, lat);
      cmp_cnt++; if (code !== 4'b0111 || pred !== 16'(exp_pred[i]) || idx !== 7'(16 + 8 * i))
        begin fail_cnt++; $display("[TB] FAIL ramp_%0d: got %b/%0d/%0d want 0111/%0d/%0d", i, code, pred, idx, exp_pred[i], 16 + 8 * i); end
    end
    encode(2'd0, -16'sd32768, rch, code, pred, idx, lat);
    cmp_cnt++; if (code !== 4'b1111 || pred !== -16'sd3627 || idx !== 7'd88)
      begin fail_cnt++; $display("[TB] FAIL swing_down: got %b/%0d/%0d want 1111/-3627/88", code, pred, idx); end
    encode(2'd0, 16'sd32767, rch, code, pred, idx, lat);
    cmp_cnt++; if (code !== 4'b0100 || pred !== 16'sd32767 || idx !== 7'd88)
      begin fail_cnt++; $display("[TB] FAIL sat_and_idx_clamp: got %b/%0d/%0d want 0100/32767/88", code, pred, idx); end
    encode(2'd0, 16'sd32767, rch, code, pred, idx, lat);
    cmp_cnt++; if (code !== 4'b0000 || pred !== 16'sd32767 || idx !== 7'd87)
      begin fail_cnt++; $display("[TB] FAIL sat_hold: got %b/%0d/%0d want 0000/32767/87", code, pred, idx); end
    for (int i = 0; i < 28; i++) begin
      encode(2'd0, 16'sd32767, rch, code, pred, idx, lat);
      cmp_cnt++; if (code !== 4'b0000 || pred !== 16'sd32767 || idx !== 7'(86 - i))
        begin fail_cnt++; $display("[TB] FAIL settle_%0d: got %b/%0d/%0d want 0000/32767/%0d", i, code, pred, idx, 86 - i); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    in_ch = 2'd3; in_sample = 16'sd1000; in_valid = 1'b1;
    @(posedge clk); #1;
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      cmp_cnt++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
        begin fail_cnt++; $display("[TB] FAIL stall_flags_%0d: out_valid=%b in_ready=%b want 1/0", i, out_valid, in_ready); end
      cmp_cnt++; if (out_ch !== 2'd3 || out_code !== 4'b0111 || out_predicted !== 16'sd11 || out_index !== 7'd8)
        begin fail_cnt++; $display("[TB] FAIL stall_hold_%0d: got %0d/%b/%0d/%0d want 3/0111/11/8", i, out_ch, out_code, out_predicted, out_index); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    cmp_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin fail_cnt++; $display("[TB] FAIL resume_ready: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    cmp_cnt++; if (in_ready !== 1'b0) begin fail_cnt++; $display("[TB] FAIL resume_accept: in_ready=%b want 0", in_ready); end
    wait_out(lat);
    cmp_cnt++; if (out_code !== 4'b0111 || out_predicted !== 16'sd41 || out_index !== 7'd16)
      begin fail_cnt++; $display("[TB] FAIL resume_result: got %b/%0d/%0d want 0111/41/16", out_code, out_predicted, out_index); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ch0 holds 32767/59 at this point.
  task automatic test_clear_inflight();
    logic [1:0] rch; logic [3:0] code; logic signed [15:0] pred; logic [6:0] idx; int lat;
    in_ch = 2'd0; in_sample = 16'sd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    clr_valid = 1'b1; clr_ch = 2'd0;
    @(posedge clk); #1;
    clr_valid = 1'b0;
    wait_out(lat);
    cmp_cnt++; if (out_code !== 4'b1111 || out_predicted !== 16'sd28894 || out_index !== 7'd67)
      begin fail_cnt++; $display("[TB] FAIL clr_inflight_result: got %b/%0d/%0d want 1111/28894/67", out_code, out_predicted, out_index); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    encode(2'd0, 16'sd1000, rch, code, pred, idx, lat);
    cmp_cnt++; if (code !== 4'b0111 || pred !== 16'sd11 || idx !== 7'd8)
      begin fail_cnt++; $display("[TB] FAIL clr_inflight_after: got %b/%0d/%0d want 0111/11/8", code, pred, idx); end
  endtask

  // ch1 holds -11/8; clearing on the accept edge must encode against 0/0.
  task automatic test_clear_accept_same_edge();
    int lat;
    in_ch = 2'd1; in_sample = 16'sd1000; in_valid = 1'b1;
    clr_valid = 1'b1; clr_ch = 2'd1;
    @(posedge clk); #1;
    in_valid = 1'b0; clr_valid = 1'b0;
    wait_out(lat);
    cmp_cnt++; if (out_code !== 4'b0111 || out_predicted !== 16'sd11 || out_index !== 7'd8)
      begin fail_cnt++; $display("[TB] FAIL clr_accept_result: got %b/%0d/%0d want 0111/11/8", out_code, out_predicted, out_index); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ch1 holds 11/8; reset mid-flight must drop the sample and clear all state.
  task automatic test_reset_midflight();
    logic [1:0] rch; logic [3:0] code; logic signed [15:0] pred; logic [6:0] idx; int lat;
    logic seen_valid;
    in_ch = 2'd1; in_sample = -16'sd1000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    cmp_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin fail_cnt++; $display("[TB] FAIL midreset_state: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    cmp_cnt++; if (seen_valid !== 1'b0) begin fail_cnt++; $display("[TB] FAIL midreset_no_output: saw out_valid=%b want 0", seen_valid); end
    encode(2'd1, -16'sd1000, rch, code, pred, idx, lat);
    cmp_cnt++; if (code !== 4'b1111 || pred !== -16'sd11 || idx !== 7'd8)
      begin fail_cnt++; $display("[TB] FAIL midreset_fresh_state: got %b/%0d/%0d want 1111/-11/8", code, pred, idx); end
  endtask

  // Scenario sequence; later scenarios rely on channel state left by earlier ones.
  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_small();
    test_saturation();
    test_backpressure();
    test_clear_inflight();
    test_clear_accept_same_edge();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
